// File: rtl/hazard_pkg.sv
// Shared constants and types for the RV32 hazard scoreboard.
// Latency classes give the cycles until a result is forwardable to EX.
package hazard_pkg;

    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = '0;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 3;

    typedef enum logic {
        CONS_NORMAL = 1'b0,
        CONS_BRANCH = 1'b1
    } consumer_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the pending
// result of a register is usable; a new set wins over the decrement.
module hazard_sb_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             set,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero
);

    assign nonzero = |cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (set) begin
                cnt <= set_val;
            end else if (nonzero) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard unit: per-register countdowns drive IF/ID
// stalls, redirect flushes follow taken control flow, ext_busy freezes all.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_LAT      = 4,
    parameter int BR_EXTRA     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 3,
    parameter int PERF_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_reg_write,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                id_is_branch,
    input  logic                id_is_jal,
    input  logic                id_is_jalr,
    input  logic                id_br_taken,
    input  logic                ext_busy,
    output logic                pc_write,
    output logic                if_id_hold,
    output logic                if_id_flush,
    output logic                id_ex_ctrl_flush,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [FL_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]    lat_sat;
    logic [CNT_W-1:0]    set_val;
    consumer_e           cons;
    logic                flush_active;
    logic                data_stall;
    logic                redirect;
    logic                issue;
    logic                issue_wr;

    // EX consumers can take a forwarded value BR_EXTRA cycles earlier
    function automatic logic src_hazard(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic [CNT_W-1:0]  c,
        input consumer_e         kind
    );
        logic hit;
        hit = used && (rs != REG_AW'(REG_X0));
        if (kind == CONS_BRANCH) begin
            return hit && (c != '0);
        end
        return hit && (c > CNT_W'(BR_EXTRA));
    endfunction

    assign cons = (id_is_branch || id_is_jalr) ? CONS_BRANCH : CONS_NORMAL;

    assign flush_active = (flush_cnt != '0);

    assign data_stall = id_valid && !flush_active &&
        (src_hazard(id_rs1_used, id_rs1, cnt[id_rs1], cons) ||
         src_hazard(id_rs2_used, id_rs2, cnt[id_rs2], cons));

    assign redirect = id_valid && !data_stall && !flush_active &&
        (id_is_jal || id_is_jalr || (id_is_branch && id_br_taken));

    assign issue    = id_valid && !ext_busy && !data_stall && !flush_active;
    assign issue_wr = issue && id_reg_write && (id_rd != REG_AW'(REG_X0));

    assign lat_sat = (id_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : id_lat;
    assign set_val = lat_sat + CNT_W'(BR_EXTRA);

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .freeze  (ext_busy),
            .set     (issue_wr && (id_rd == REG_AW'(r))),
            .set_val (set_val),
            .cnt     (cnt[r]),
            .nonzero (busy[r])
        );
    end

    assign pending_mask = busy;

    // Reset forces the documented idle outputs regardless of inputs
    always_comb begin
        pc_write         = 1'b1;
        if_id_hold       = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_ctrl_flush = 1'b0;
        if (rst_n) begin
            if (ext_busy) begin
                pc_write   = 1'b0;
                if_id_hold = 1'b0;
            end else if (data_stall) begin
                pc_write         = 1'b0;
                if_id_hold       = 1'b0;
                id_ex_ctrl_flush = 1'b1;
            end else if (redirect || flush_active) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (!ext_busy) begin
            if (redirect) begin
                flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
            end else if (flush_active) begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!ext_busy && data_stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit with FLUSH_CYCLES=2.
// Inputs change 1ns after posedge; outputs are sampled 3ns later.
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    localparam int NUM_REGS     = 32;
    localparam int RAW          = 5;
    localparam int MAX_LAT      = 4;
    localparam int BR_EXTRA     = 1;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 3;
    localparam int PERF_W       = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [RAW-1:0]      id_rs1;
    logic [RAW-1:0]      id_rs2;
    logic                id_rs1_used;
    logic                id_rs2_used;
    logic [RAW-1:0]      id_rd;
    logic                id_reg_write;
    logic [CNT_W-1:0]    id_lat;
    logic                id_is_branch;
    logic                id_is_jal;
    logic                id_is_jalr;
    logic                id_br_taken;
    logic                ext_busy;
    logic                pc_write;
    logic                if_id_hold;
    logic                if_id_flush;
    logic                id_ex_ctrl_flush;
    logic [NUM_REGS-1:0] pending_mask;
    logic [PERF_W-1:0]   stall_cycles;

    int n_vec = 0;
    int n_err = 0;
    int exp_stalls = 0;
    int n;

    hazard_scoreboard_unit #(
        .NUM_REGS     (NUM_REGS),
        .REG_AW       (RAW),
        .MAX_LAT      (MAX_LAT),
        .BR_EXTRA     (BR_EXTRA),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W),
        .PERF_W       (PERF_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rs1_used      (id_rs1_used),
        .id_rs2_used      (id_rs2_used),
        .id_rd            (id_rd),
        .id_reg_write     (id_reg_write),
        .id_lat           (id_lat),
        .id_is_branch     (id_is_branch),
        .id_is_jal        (id_is_jal),
        .id_is_jalr       (id_is_jalr),
        .id_br_taken      (id_br_taken),
        .ext_busy         (ext_busy),
        .pc_write         (pc_write),
        .if_id_hold       (if_id_hold),
        .if_id_flush      (if_id_flush),
        .id_ex_ctrl_flush (id_ex_ctrl_flush),
        .pending_mask     (pending_mask),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && id_valid) begin
            assert (id_lat <= CNT_W'(MAX_LAT))
                else $error("illegal id_lat %0d", id_lat);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_lat       = '0;
        id_is_branch = 1'b0;
        id_is_jal    = 1'b0;
        id_is_jalr   = 1'b0;
        id_br_taken  = 1'b0;
        ext_busy     = 1'b0;
    endtask

    task automatic idle(input int k);
        clear();
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic op_wr(input logic [RAW-1:0] rd, input int lat);
        clear();
        id_valid     = 1'b1;
        id_rd        = rd;
        id_reg_write = 1'b1;
        id_lat       = CNT_W'(lat);
    endtask

    task automatic op_use(input logic [RAW-1:0] rs1);
        clear();
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs1_used = 1'b1;
    endtask

    task automatic op_br(input logic [RAW-1:0] rs1, input logic tk);
        op_use(rs1);
        id_is_branch = 1'b1;
        id_br_taken  = tk;
    endtask

    // Counts stall cycles until the instruction in ID issues
    task automatic run_issue(output int cnt);
        cnt = 0;
        #3;
        while (!pc_write && cnt < 8) begin
            cnt++;
            cyc();
            #3;
        end
        cyc();
        clear();
    endtask

    // Counts consecutive IF/ID flush cycles starting now
    task automatic run_flush(output int cnt);
        cnt = 0;
        #3;
        while (if_id_flush && cnt < 8) begin
            cnt++;
            cyc();
            clear();
            #3;
        end
        cyc();
        clear();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear();
        #3;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_hold", if_id_hold, 1);
        chk("rst_if_id_flush", if_id_flush, 0);
        chk("rst_ex_flush", id_ex_ctrl_flush, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_stalls", stall_cycles, 0);
        cyc();
        rst_n = 1'b1;

        op_wr(5, LAT_LOAD);
        #3 chk("lu_issue_pc", pc_write, 1);
        cyc();
        op_use(5);
        #3;
        chk("lu_stall_pc", pc_write, 0);
        chk("lu_stall_hold", if_id_hold, 0);
        chk("lu_stall_exfl", id_ex_ctrl_flush, 1);
        chk("lu_stall_iffl", if_id_flush, 0);
        chk("lu_mask5", pending_mask[5], 1);
        cyc();
        #3;
        chk("lu_go_pc", pc_write, 1);
        chk("lu_go_exfl", id_ex_ctrl_flush, 0);
        chk("lu_stalls", stall_cycles, 1);
        exp_stalls = 1;
        cyc();
        idle(3);

        op_wr(6, LAT_ALU);
        cyc();
        op_br(6, 1'b0);
        run_issue(n);
        chk("alu_br_stalls", n, 1);
        exp_stalls += 1;
        idle(3);

        op_wr(6, LAT_LOAD);
        cyc();
        op_br(6, 1'b0);
        run_issue(n);
        chk("ld_br_stalls", n, 2);
        exp_stalls += 2;
        idle(3);

        op_wr(6, LAT_ALU);
        cyc();
        op_use(6);
        run_issue(n);
        chk("alu_alu_stalls", n, 0);
        idle(3);
        chk("perf_after_raw", stall_cycles, exp_stalls);

        op_br(1, 1'b1);
        #3 chk("beq_tk_pc", pc_write, 1);
        #0 run_flush(n);
        chk("beq_tk_flush", n, 2);
        idle(2);
        op_br(1, 1'b0);
        run_flush(n);
        chk("beq_nt_flush", n, 0);
        idle(2);
        clear();
        id_valid  = 1'b1;
        id_is_jal = 1'b1;
        run_flush(n);
        chk("jal_flush", n, 2);
        idle(2);
        op_use(1);
        id_is_jalr = 1'b1;
        run_flush(n);
        chk("jalr_flush", n, 2);
        idle(3);

        op_wr(7, LAT_LOAD);
        cyc();
        op_use(7);
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("frz_mask7", pending_mask[7], 1);
            chk("frz_pc", pc_write, 0);
            chk("frz_exfl", id_ex_ctrl_flush, 0);
            chk("frz_stalls", stall_cycles, exp_stalls);
            cyc();
        end
        ext_busy = 1'b0;
        run_issue(n);
        chk("frz_release_stalls", n, 1);
        exp_stalls += 1;
        idle(3);

        op_wr(8, LAT_LOAD);
        cyc();
        clear();
        id_valid    = 1'b1;
        id_rs2      = 8;
        id_rs2_used = 1'b1;
        run_issue(n);
        chk("rs2_stalls", n, 1);
        exp_stalls += 1;
        idle(3);
        chk("perf_total", stall_cycles, exp_stalls);

        op_wr(0, LAT_LOAD);
        cyc();
        op_use(0);
        #3;
        chk("x0_pc", pc_write, 1);
        chk("x0_mask", pending_mask, 0);
        cyc();
        idle(2);

        op_wr(9, LAT_MUL);
        cyc();
        op_wr(9, LAT_ALU);
        #3 chk("waw_mask_a", pending_mask[9], 1);
        cyc();
        clear();
        #3 chk("waw_mask_b", pending_mask[9], 1);
        cyc();
        #3 chk("waw_mask_c", pending_mask[9], 0);
        cyc();
        idle(3);

        op_wr(5, LAT_LOAD);
        cyc();
        op_use(5);
        #3 chk("rst_mid_stall", pc_write, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pc", pc_write, 1);
        chk("rst_mid_hold", if_id_hold, 1);
        chk("rst_mid_exfl", id_ex_ctrl_flush, 0);
        chk("rst_mid_iffl", if_id_flush, 0);
        chk("rst_mid_mask", pending_mask, 0);
        chk("rst_mid_stalls", stall_cycles, 0);
        cyc();
        rst_n = 1'b1;
        #3;
        chk("post_rst_pc", pc_write, 1);
        chk("post_rst_mask", pending_mask, 0);
        cyc();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
